// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler that drives an external ALU and returns results.
// Optional EXEC timeout abort is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req0_first,
  input  logic [31:0] req0_second,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req1_first,
  input  logic [31:0] req1_second,
  input  logic [1:0]  req1_op,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_error,
  output logic [31:0] alu_input_first,
  output logic [31:0] alu_input_second,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_op_done
);

  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpNop = 2'b11;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
`else
  // Only "past the first EXEC cycle" is needed, so a single saturating bit suffices.
  localparam int unsigned CntW = 1;
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     first_q, first_d;
  logic [31:0]     second_q, second_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     result_q, result_d;
  logic            zero_q, zero_d;
`ifdef ALU_SCHED_TIMEOUT_EN
  logic            error_q, error_d;
`endif

  logic [1:0] grant;
  logic       done_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= OpNop;
      first_q  <= '0;
      second_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      first_q  <= first_d;
      second_q <= second_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_SCHED_TIMEOUT_EN
      error_q  <= error_d;
`endif
    end
  end

  // rr_q set means requester 1 wins a tie.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign done_now = (op_q == OpMul) ? ((cnt_q != '0) && alu_op_done) : (cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    first_d  = first_q;
    second_d = second_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_SCHED_TIMEOUT_EN
    error_d  = error_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant != 2'b00) begin
          owner_d  = grant[1];
          rr_d     = ~grant[1];
          op_d     = grant[1] ? req1_op : req0_op;
          first_d  = grant[1] ? req1_first : req0_first;
          second_d = grant[1] ? req1_second : req0_second;
          if (op_d == OpNop) begin
            state_d  = StResp;
            result_d = '0;
            zero_d   = 1'b1;
`ifdef ALU_SCHED_TIMEOUT_EN
            error_d  = 1'b0;
`endif
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
`ifdef ALU_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`else
        cnt_d = 1'b1;
`endif
        if (done_now) begin
          state_d  = StResp;
          result_d = alu_result;
          zero_d   = (op_q == OpMul) ? (alu_result == '0) : alu_zero;
`ifdef ALU_SCHED_TIMEOUT_EN
          error_d  = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = StResp;
          result_d = '0;
          zero_d   = 1'b0;
          error_d  = 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready        = grant;
    resp_valid       = 2'b00;
    resp_result      = '0;
    resp_zero        = 1'b0;
    resp_error       = 1'b0;
    alu_op           = OpNop;
    alu_input_first  = '0;
    alu_input_second = '0;
    if (state_q == StResp) begin
      resp_valid  = owner_q ? 2'b10 : 2'b01;
      resp_result = result_q;
      resp_zero   = zero_q;
`ifdef ALU_SCHED_TIMEOUT_EN
      resp_error  = error_q;
`endif
    end
    if (state_q == StExec) begin
      alu_op           = op_q;
      alu_input_first  = first_q;
      alu_input_second = (op_q == OpSub) ? (~second_q + 32'd1) : second_q;
    end
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, EXEC cycles before abort (used only with ALU_SCHED_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  2  bit i = requester i presents an operation.
REQ-005 req0_first / req0_second  in  32 each  requester 0 operands.
REQ-006 req0_op  in  2  requester 0 op: 00 add, 01 sub, 10 mul, 11 nop.
REQ-007 req1_first / req1_second / req1_op  in  32/32/2  requester 1 operands and op, same encoding.
REQ-008 req_ready  out  2  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
REQ-009 resp_valid  out  2  one-hot; the completed operation belongs to requester i.
REQ-010 resp_ready  in  2  requester i accepts its response.
REQ-011 resp_result  out  32  result; resp_zero  out  1  result==0 flag.
REQ-012 resp_error  out  1  operation aborted by timeout.
REQ-013 alu_input_first / alu_input_second  out  32 each  ALU operands.
REQ-014 alu_op  out  2  ALU op; 2'b11 = idle.
REQ-015 alu_result  in  32; alu_zero  in  1; alu_op_done  in  1  from ALU.

Function
REQ-016 The scheduler SHALL use the FSM IDLE -> EXEC -> RESP -> IDLE, plus IDLE -> RESP for nop.
REQ-017 In IDLE, req_ready SHALL be combinational and one-hot: a lone valid is granted; when both are valid, the round-robin pointer picks; outside IDLE, req_ready SHALL be 2'b00.
REQ-018 After each grant, the pointer SHALL point to the other requester; reset value favours requester 0.
REQ-019 Requesters SHALL hold operands and op stable while req_valid is high until the handshake; the scheduler registers them at the handshake edge.
REQ-020 In EXEC, alu_op SHALL equal the registered op and alu_input_first SHALL equal the registered first operand.
REQ-021 For op 01, alu_input_second SHALL be (~second + 1) mod 2^32; for all other ops it SHALL be the second operand unchanged.
REQ-022 Outside EXEC, alu_op SHALL be 2'b11 and the ALU operand outputs SHALL be 0.
REQ-023 Add/sub SHALL complete on the 2nd EXEC cycle, capturing alu_result/alu_zero at that edge; accept at edge t gives resp_valid high after edge t+2.
REQ-024 Mul SHALL complete at the first edge where the EXEC count is >=2 and alu_op_done=1; alu_op_done SHALL be ignored during the first EXEC cycle.
REQ-025 Mul resp_zero SHALL be recomputed as (alu_result==0).
REQ-026 Nop SHALL go IDLE -> RESP without driving the ALU, returning result 0, zero 1, error 0.
REQ-027 In RESP, resp_valid[owner] and resp_result/resp_zero/resp_error SHALL hold stable until resp_ready[owner]=1, then go to IDLE; resp_ready of the non-owner SHALL be ignored.
REQ-028 New requests arriving during EXEC/RESP SHALL wait, with no grant, until IDLE.

Reset
REQ-029 rst_n low SHALL immediately force: IDLE, req_ready 0, resp_valid 0, resp_result 0, resp_zero 0, resp_error 0, alu_op 2'b11, ALU operands 0, pointer to requester 0, EXEC count 0.
REQ-030 Reset during EXEC or RESP SHALL discard the in-flight operation without a response.

Configuration
REQ-031 With ALU_SCHED_TIMEOUT_EN defined, an operation SHALL abort if EXEC reaches TIMEOUT_CYCLES cycles without completion: go to RESP with result 0, zero 0, error 1.
REQ-032 Without ALU_SCHED_TIMEOUT_EN, EXEC SHALL wait indefinitely, resp_error SHALL be tied 0, and no timeout counter SHALL exist.

Verification
REQ-033 req0 add 5+7, resp_ready=1 -> resp_valid=01 two edges after accept, result 12, zero 0.
REQ-034 req1 sub 9-9 -> alu_input_second=0xFFFFFFF7; resp_valid=10, result 0, zero 1 (carry ignored).
REQ-035 Both valid continuously with resp_ready=11 -> grants alternate 01,10,01,10; no starvation.
REQ-036 mul 6*7 with alu_op_done dropping for N cycles -> resp 42 only after alu_op_done returns; alu_op=10 throughout EXEC, then 11.
REQ-037 Response with resp_ready=0 for 5 cycles -> outputs stable, req_ready=00 for all 5 cycles, then IDLE on accept.
REQ-038 rst_n low mid-mul -> immediate idle outputs and no response; with the macro and alu_op_done held 0 -> error=1 after 64 EXEC cycles.
